// File: rtl/matmul2x2_if.sv
// Operand/result handshake and external multiplier bus for matmul2x2_seq.
// The slave modport is the sequencer side; master is the environment driving operands and the multiplier.
interface matmul2x2_if #(
    parameter int DATA_W = 8,
    parameter int PROD_W = 17
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DATA_W-1:0]   in_a;
    logic [4*DATA_W-1:0]   in_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*PROD_W-1:0]   out_c;
    logic [DATA_W-1:0]     mul_a;
    logic [DATA_W-1:0]     mul_b;
    logic [PROD_W-1:0]     mul_p;
    logic                  busy;

    modport slave (
        input  in_valid, in_a, in_b, out_ready, mul_p,
        output in_ready, out_valid, out_c, mul_a, mul_b, busy
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, mul_p,
        input  in_ready, out_valid, out_c, mul_a, mul_b, busy
    );
endinterface

// File: rtl/matmul2x2_seq.sv
// 2x2 matrix multiply sequencer: issues the 8 element products to one external multiplier and accumulates C = A*B.
// Optional macro MATMUL_MUL_PIPE_EN registers mul_p before accumulation (one extra RUN cycle).
module matmul2x2_seq #(
    parameter int DATA_W = 8,
    parameter int PROD_W = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    matmul2x2_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [4*DATA_W-1:0]      a_q, b_q;
    logic [2:0]               step_q;
    logic                     issued_q;
    logic                     p_vld_q;
    logic [2:0]               p_idx_q;
    logic [DATA_W-1:0]        mul_a_q, mul_b_q;
    logic [3:0][PROD_W-1:0]   c_q;
    logic                     out_valid_q, out_valid_d;
    logic                     in_ready_q, in_ready_d;
    logic                     busy_q, busy_d;
    logic                     acc_vld_s;
    logic [2:0]               acc_idx_s;
    logic [PROD_W-1:0]        acc_val_s;
    logic                     accept_s, last_acc_s, handoff_s;

    function automatic logic [DATA_W-1:0] elem(input logic [4*DATA_W-1:0] m, input logic [1:0] idx);
        return m[int'(idx)*DATA_W +: DATA_W];
    endfunction

    assign accept_s   = (state_q == S_IDLE) && bus.in_valid;
    assign last_acc_s = (state_q == S_RUN) && acc_vld_s && (acc_idx_s == 3'd7);
    assign handoff_s  = (state_q == S_DONE) && bus.out_ready;

`ifdef MATMUL_MUL_PIPE_EN
    logic                     pp_vld_q;
    logic [2:0]               pp_idx_q;
    logic [PROD_W-1:0]        pp_q;

    // Product capture stage for a registered multiplier path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pp_vld_q <= 1'b0;
            pp_idx_q <= 3'd0;
            pp_q     <= '0;
        end else if (state_q == S_RUN) begin
            pp_vld_q <= p_vld_q;
            pp_idx_q <= p_idx_q;
            pp_q     <= bus.mul_p;
        end else begin
            pp_vld_q <= 1'b0;
            pp_idx_q <= 3'd0;
            pp_q     <= '0;
        end
    end

    assign acc_vld_s = pp_vld_q;
    assign acc_idx_s = pp_idx_q;
    assign acc_val_s = pp_q;
`else
    assign acc_vld_s = p_vld_q;
    assign acc_idx_s = p_idx_q;
    assign acc_val_s = bus.mul_p;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_s)   state_d = S_RUN;  else state_d = S_IDLE;
            S_RUN:   if (last_acc_s) state_d = S_DONE; else state_d = S_RUN;
            S_DONE:  if (handoff_s)  state_d = S_IDLE; else state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode, registered below so flags line up with the state they describe
    always_comb begin
        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d == S_RUN);
        out_valid_d = (state_d == S_DONE);
    end

    // Handshake flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Operand capture and product issue: step k drives A[k2][k0] * B[k0][k1]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            step_q   <= 3'd0;
            issued_q <= 1'b0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            p_vld_q  <= 1'b0;
            p_idx_q  <= 3'd0;
        end else if (accept_s) begin
            a_q      <= bus.in_a;
            b_q      <= bus.in_b;
            step_q   <= 3'd0;
            issued_q <= 1'b0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            p_vld_q  <= 1'b0;
            p_idx_q  <= 3'd0;
        end else if ((state_q == S_RUN) && !issued_q) begin
            mul_a_q  <= elem(a_q, {step_q[2], step_q[0]});
            mul_b_q  <= elem(b_q, {step_q[0], step_q[1]});
            p_vld_q  <= 1'b1;
            p_idx_q  <= step_q;
            step_q   <= step_q + 3'd1;
            issued_q <= (step_q == 3'd7);
        end else begin
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            p_vld_q  <= 1'b0;
            p_idx_q  <= 3'd0;
        end
    end

    // Accumulator: even steps load C[r][c], odd steps add the second product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= '0;
        end else if ((state_q == S_RUN) && acc_vld_s) begin
            if (!acc_idx_s[0]) begin
                c_q[{acc_idx_s[2], acc_idx_s[1]}] <= acc_val_s;
            end else begin
                c_q[{acc_idx_s[2], acc_idx_s[1]}] <= c_q[{acc_idx_s[2], acc_idx_s[1]}] + acc_val_s;
            end
        end else begin
            c_q <= c_q;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_c     = c_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;

endmodule

// File: tb/tb_matmul2x2_seq.sv
// Directed self-checking bench for matmul2x2_seq; models the external multiplier combinationally.
module tb_matmul2x2_seq;

`ifdef MATMUL_MUL_PIPE_EN
    localparam int LAT = 10;
`else
    localparam int LAT = 9;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    matmul2x2_if #(.DATA_W(8), .PROD_W(17)) mb ();

    matmul2x2_seq #(.DATA_W(8), .PROD_W(17)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mb)
    );

    always #5 clk = ~clk;

    assign mb.mul_p = 17'(mb.mul_a) * 17'(mb.mul_b);

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk8(input logic [7:0] e00, input logic [7:0] e01,
                                        input logic [7:0] e10, input logic [7:0] e11);
        return {e11, e10, e01, e00};
    endfunction

    function automatic logic [67:0] pk17(input logic [16:0] e00, input logic [16:0] e01,
                                         input logic [16:0] e10, input logic [16:0] e11);
        return {e11, e10, e01, e00};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        mb.in_a     = a;
        mb.in_b     = b;
        mb.in_valid = 1'b1;
        tick();
        mb.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int start);
        int n;
        n = start;
        while (mb.out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 68'(n), 68'(LAT));
    endtask

    task automatic run_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [67:0] exp_c);
        mb.out_ready = 1'b1;
        accept(a, b);
        chk({tag, "_busy"}, 68'(mb.busy), 68'd1);
        wait_valid({tag, "_lat"}, 0);
        chk({tag, "_c"}, mb.out_c, exp_c);
        chk({tag, "_mula_done"}, 68'(mb.mul_a), 68'd0);
        tick();
        chk({tag, "_vld_drop"}, 68'(mb.out_valid), 68'd0);
        chk({tag, "_rdy_back"}, 68'(mb.in_ready), 68'd1);
    endtask

    initial begin
        logic [7:0] ea [4];
        logic [7:0] eb [4];
        logic [2:0] kk;
        int         n;

        rst_n        = 1'b0;
        mb.in_valid  = 1'b0;
        mb.out_ready = 1'b0;
        mb.in_a      = 32'd0;
        mb.in_b      = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 68'(mb.out_valid), 68'd0);
        chk("rst_in_ready", 68'(mb.in_ready), 68'd1);
        chk("rst_out_c", mb.out_c, 68'd0);
        chk("rst_mul_a", 68'(mb.mul_a), 68'd0);
        chk("rst_busy", 68'(mb.busy), 68'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic product, then the overflow and zero boundaries
        run_case("t1", pk8(8'd1, 8'd2, 8'd3, 8'd4), pk8(8'd5, 8'd6, 8'd7, 8'd8),
                 pk17(17'd19, 17'd22, 17'd43, 17'd50));
        run_case("t2_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 pk17(17'h1FC02, 17'h1FC02, 17'h1FC02, 17'h1FC02));
        run_case("t2_zero", 32'd0, pk8(8'h12, 8'h34, 8'h56, 8'h78), 68'd0);

        // Identity times B with the multiplier operand sequence watched
        ea[0] = 8'd1;  ea[1] = 8'd0;  ea[2] = 8'd0;  ea[3] = 8'd1;
        eb[0] = 8'hAA; eb[1] = 8'h55; eb[2] = 8'h63; eb[3] = 8'hC7;
        mb.out_ready = 1'b1;
        accept(pk8(ea[0], ea[1], ea[2], ea[3]), pk8(eb[0], eb[1], eb[2], eb[3]));
        for (int k = 0; k < 8; k++) begin
            kk = 3'(k);
            tick();
            chk($sformatf("t3_mula%0d", k), 68'(mb.mul_a), 68'(ea[{kk[2], kk[0]}]));
            chk($sformatf("t3_mulb%0d", k), 68'(mb.mul_b), 68'(eb[{kk[0], kk[1]}]));
        end
        wait_valid("t3_lat", 8);
        chk("t3_c", mb.out_c, pk17(17'hAA, 17'h55, 17'h63, 17'hC7));
        tick();

        // Backpressure: result held, new operands refused
        mb.out_ready = 1'b0;
        accept(pk8(8'd1, 8'd2, 8'd3, 8'd4), pk8(8'd5, 8'd6, 8'd7, 8'd8));
        wait_valid("t4_lat", 0);
        for (int i = 0; i < 20; i++) begin
            mb.in_valid = i[0];
            mb.in_a     = 32'hDEAD_0000 + 32'(i);
            mb.in_b     = 32'h0000_BEEF;
            tick();
            chk($sformatf("t4_vld%0d", i), 68'(mb.out_valid), 68'd1);
            chk($sformatf("t4_rdy%0d", i), 68'(mb.in_ready), 68'd0);
            chk($sformatf("t4_c%0d", i), mb.out_c, pk17(17'd19, 17'd22, 17'd43, 17'd50));
        end
        mb.in_valid  = 1'b0;
        mb.out_ready = 1'b1;
        tick();
        chk("t4_vld_drop", 68'(mb.out_valid), 68'd0);
        tick();
        chk("t4_no_accept", 68'(mb.busy), 68'd0);
        chk("t4_c_kept", mb.out_c, pk17(17'd19, 17'd22, 17'd43, 17'd50));

        // Asynchronous reset in the middle of a run
        accept(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("t5_vld", 68'(mb.out_valid), 68'd0);
        chk("t5_rdy", 68'(mb.in_ready), 68'd1);
        chk("t5_c", mb.out_c, 68'd0);
        chk("t5_busy", 68'(mb.busy), 68'd0);
        #3;
        rst_n = 1'b1;
        tick();
        run_case("t5_fresh", pk8(8'h7B, 8'h00, 8'h00, 8'h25), pk8(8'h2D, 8'h00, 8'h00, 8'h49),
                 pk17(17'd5535, 17'd0, 17'd0, 17'd2701));

        // Back-to-back with in_valid held high
        mb.out_ready = 1'b1;
        mb.in_a      = pk8(8'd2, 8'd3, 8'd4, 8'd5);
        mb.in_b      = pk8(8'd6, 8'd7, 8'd8, 8'd9);
        mb.in_valid  = 1'b1;
        tick();
        mb.in_a = pk8(8'd10, 8'd0, 8'd1, 8'd1);
        mb.in_b = pk8(8'd1, 8'd2, 8'd3, 8'd4);
        wait_valid("t6_lat1", 0);
        chk("t6_c1", mb.out_c, pk17(17'd36, 17'd41, 17'd64, 17'd73));
        tick();
        chk("t6_gap_vld", 68'(mb.out_valid), 68'd0);
        chk("t6_gap_rdy", 68'(mb.in_ready), 68'd1);
        tick();
        mb.in_valid = 1'b0;
        chk("t6_acc2_busy", 68'(mb.busy), 68'd1);
        chk("t6_acc2_rdy", 68'(mb.in_ready), 68'd0);
        wait_valid("t6_lat2", 0);
        chk("t6_c2", mb.out_c, pk17(17'd10, 17'd20, 17'd4, 17'd6));
        tick();
        chk("t6_end_vld", 68'(mb.out_valid), 68'd0);

        n = n_cmp;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, n_bad);
        $finish;
    end

endmodule
